// File: rtl/counter_b4_pkg.sv
// Shared definitions for the counter_b4 family: mode encodings and monitor states.
package counter_b4_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FAULT = 2'b10
  } mon_state_e;

endpackage

// File: rtl/counter_b4_model.sv
// Golden cycle-accurate model of counter_b4: Q/rco/load registers updated every edge.
module counter_b4_model
  import counter_b4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dut_reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             load
);

  logic [WIDTH:0]   up1_sum;
  logic [WIDTH:0]   up3_sum;
  logic [WIDTH-1:0] dn1_val;

  // The carry bit of the widened sums is exactly the rco condition for the up modes.
  assign up1_sum = {1'b0, q} + (WIDTH+1)'(1);
  assign up3_sum = {1'b0, q} + (WIDTH+1)'(3);
  assign dn1_val = q - WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      rco  <= 1'b0;
      load <= 1'b0;
    end else if (dut_reset) begin
      q    <= '0;
      rco  <= 1'b0;
      load <= 1'b0;
    end else if (!enable) begin
      rco  <= 1'b0;
      load <= 1'b0;
    end else begin
      case (mode)
        MODE_UP: begin
          q    <= up1_sum[WIDTH-1:0];
          rco  <= up1_sum[WIDTH];
          load <= 1'b0;
        end
        MODE_DOWN: begin
          q    <= dn1_val;
          rco  <= (q == '0);
          load <= 1'b0;
        end
        MODE_UP3: begin
          q    <= up3_sum[WIDTH-1:0];
          rco  <= up3_sum[WIDTH];
          load <= 1'b0;
        end
        default: begin
          q    <= d;
          rco  <= 1'b0;
          load <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_b4_monitor.sv
// Passive checker for counter_b4: runs the golden model alongside the counter and
// flags, counts and snapshots any cycle where the observed outputs disagree.
module counter_b4_monitor
  import counter_b4_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 b4_clk,
  input  logic                 b4_reset,
  input  logic                 b4_dut_reset,
  input  logic                 b4_enable,
  input  logic [1:0]           b4_mode,
  input  logic [WIDTH-1:0]     b4_D,
  input  logic [WIDTH-1:0]     b4_Q,
  input  logic                 b4_rco,
  input  logic                 b4_load,
  input  logic                 mon_clear,
  output logic                 mon_synced,
  output logic                 mon_err,
  output logic                 mon_err_sticky,
  output logic [ERR_CNT_W-1:0] mon_err_cnt,
  output logic [WIDTH+1:0]     mon_first_exp,
  output logic [WIDTH+1:0]     mon_first_obs
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  mon_state_e       state;
  logic [WIDTH-1:0] m_q;
  logic             m_rco;
  logic             m_load;
  logic [WIDTH+1:0] exp_p0;
  logic [WIDTH+1:0] obs_p0;
  logic             mismatch_p0;
  logic             sync_evt_p0;

  counter_b4_model #(.WIDTH(WIDTH)) u_model (
    .clk       (b4_clk),
    .rst_n     (b4_reset),
    .dut_reset (b4_dut_reset),
    .enable    (b4_enable),
    .mode      (b4_mode),
    .d         (b4_D),
    .q         (m_q),
    .rco       (m_rco),
    .load      (m_load)
  );

  // Stage p0: model and observed outputs, both produced by the previous edge.
  assign exp_p0      = {m_rco, m_load, m_q};
  assign obs_p0      = {b4_rco, b4_load, b4_Q};
  assign mismatch_p0 = (state == CHECK) && (obs_p0 !== exp_p0);
  assign sync_evt_p0 = b4_dut_reset || (b4_enable && (b4_mode == MODE_LOAD));
  assign mon_synced  = (state == CHECK);

  // Stage p1: registered verdict, count and first-failure snapshot.
  always_ff @(posedge b4_clk or negedge b4_reset) begin
    if (!b4_reset) begin
      state          <= IDLE;
      mon_err        <= 1'b0;
      mon_err_sticky <= 1'b0;
      mon_err_cnt    <= '0;
      mon_first_exp  <= '0;
      mon_first_obs  <= '0;
    end else if (mon_clear) begin
      state          <= IDLE;
      mon_err        <= 1'b0;
      mon_err_sticky <= 1'b0;
      mon_err_cnt    <= '0;
      mon_first_exp  <= '0;
      mon_first_obs  <= '0;
    end else begin
      mon_err <= mismatch_p0;
      case (state)
        IDLE:    if (sync_evt_p0) state <= CHECK;
        CHECK:   if (mismatch_p0 && (STOP_ON_ERR != 0)) state <= FAULT;
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
      if (mismatch_p0) begin
        mon_err_cnt    <= sat_inc(mon_err_cnt);
        mon_err_sticky <= 1'b1;
        if (!mon_err_sticky) begin
          mon_first_exp <= exp_p0;
          mon_first_obs <= obs_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_b4_monitor.sv
// Bench for counter_b4_monitor: acts as the counter (with optional corruption) and
// predicts the monitor outputs of three configurations from an arithmetic model.
module tb_counter_b4_monitor;

  localparam int S_IDLE  = 0;
  localparam int S_CHECK = 1;
  localparam int S_FAULT = 2;

  logic       b4_clk = 1'b0;
  logic       b4_reset = 1'b0;
  logic       b4_dut_reset = 1'b0;
  logic       b4_enable = 1'b0;
  logic       mon_clear = 1'b0;
  logic [1:0] b4_mode = 2'b00;
  logic [3:0] b4_D = 4'h0;
  logic [3:0] b4_Q = 4'h0;
  logic       b4_rco = 1'b0;
  logic       b4_load = 1'b0;

  logic       syn_o [3];
  logic       err_o [3];
  logic       stk_o [3];
  logic [5:0] fe_o  [3];
  logic [5:0] fo_o  [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  int         cq = 0;
  logic       crco = 1'b0, cload = 1'b0;
  int         st   [3];
  int         cnt  [3];
  logic       err_m[3];
  logic       stk_m[3];
  logic [5:0] fe_m [3];
  logic [5:0] fo_m [3];
  int         cmax [3] = '{255, 255, 3};
  logic       stop [3] = '{1'b0, 1'b1, 1'b0};

  always #5 b4_clk = ~b4_clk;

  counter_b4_monitor #(.WIDTH(4), .ERR_CNT_W(8), .STOP_ON_ERR(0)) dut0 (
    .b4_clk(b4_clk), .b4_reset(b4_reset), .b4_dut_reset(b4_dut_reset),
    .b4_enable(b4_enable), .b4_mode(b4_mode), .b4_D(b4_D), .b4_Q(b4_Q),
    .b4_rco(b4_rco), .b4_load(b4_load), .mon_clear(mon_clear),
    .mon_synced(syn_o[0]), .mon_err(err_o[0]), .mon_err_sticky(stk_o[0]),
    .mon_err_cnt(cnt0), .mon_first_exp(fe_o[0]), .mon_first_obs(fo_o[0]));

  counter_b4_monitor #(.WIDTH(4), .ERR_CNT_W(8), .STOP_ON_ERR(1)) dut1 (
    .b4_clk(b4_clk), .b4_reset(b4_reset), .b4_dut_reset(b4_dut_reset),
    .b4_enable(b4_enable), .b4_mode(b4_mode), .b4_D(b4_D), .b4_Q(b4_Q),
    .b4_rco(b4_rco), .b4_load(b4_load), .mon_clear(mon_clear),
    .mon_synced(syn_o[1]), .mon_err(err_o[1]), .mon_err_sticky(stk_o[1]),
    .mon_err_cnt(cnt1), .mon_first_exp(fe_o[1]), .mon_first_obs(fo_o[1]));

  counter_b4_monitor #(.WIDTH(4), .ERR_CNT_W(2), .STOP_ON_ERR(0)) dut2 (
    .b4_clk(b4_clk), .b4_reset(b4_reset), .b4_dut_reset(b4_dut_reset),
    .b4_enable(b4_enable), .b4_mode(b4_mode), .b4_D(b4_D), .b4_Q(b4_Q),
    .b4_rco(b4_rco), .b4_load(b4_load), .mon_clear(mon_clear),
    .mon_synced(syn_o[2]), .mon_err(err_o[2]), .mon_err_sticky(stk_o[2]),
    .mon_err_cnt(cnt2), .mon_first_exp(fe_o[2]), .mon_first_obs(fo_o[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      default: return {6'b0, cnt2};
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("synced%0d", i), 32'(syn_o[i]), 32'(st[i] == S_CHECK));
      check_eq($sformatf("err%0d", i), 32'(err_o[i]), 32'(err_m[i]));
      check_eq($sformatf("sticky%0d", i), 32'(stk_o[i]), 32'(stk_m[i]));
      check_eq($sformatf("cnt%0d", i), 32'(dut_cnt(i)), 32'(cnt[i]));
      check_eq($sformatf("first_exp%0d", i), 32'(fe_o[i]), 32'(fe_m[i]));
      check_eq($sformatf("first_obs%0d", i), 32'(fo_o[i]), 32'(fo_m[i]));
    end
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < 3; i++) begin
      st[i] = S_IDLE; cnt[i] = 0; err_m[i] = 1'b0; stk_m[i] = 1'b0;
      fe_m[i] = 6'h0; fo_m[i] = 6'h0;
    end
  endtask

  // One rising edge of the world: monitors judge pre-edge values, then the counter advances.
  task automatic model_edge();
    logic [5:0] e, o;
    logic       mm;
    e = {crco, cload, 4'(cq)};
    o = {b4_rco, b4_load, b4_Q};
    for (int i = 0; i < 3; i++) begin
      if (mon_clear) begin
        st[i] = S_IDLE; cnt[i] = 0; err_m[i] = 1'b0; stk_m[i] = 1'b0;
        fe_m[i] = 6'h0; fo_m[i] = 6'h0;
      end else begin
        mm = (st[i] == S_CHECK) && (o !== e);
        err_m[i] = mm;
        if (mm) begin
          if (cnt[i] < cmax[i]) cnt[i]++;
          if (!stk_m[i]) begin fe_m[i] = e; fo_m[i] = o; end
          stk_m[i] = 1'b1;
          if (stop[i]) st[i] = S_FAULT;
        end else if (st[i] == S_IDLE && (b4_dut_reset || (b4_enable && b4_mode == 2'b11)))
          st[i] = S_CHECK;
      end
    end
    if (b4_dut_reset) begin
      cq = 0; crco = 1'b0; cload = 1'b0;
    end else if (!b4_enable) begin
      crco = 1'b0; cload = 1'b0;
    end else begin
      case (b4_mode)
        2'b00:   begin crco = (cq == 15);    cq = (cq + 1) % 16;  cload = 1'b0; end
        2'b01:   begin crco = (cq == 0);     cq = (cq + 15) % 16; cload = 1'b0; end
        2'b10:   begin crco = (cq + 3 > 15); cq = (cq + 3) % 16;  cload = 1'b0; end
        default: begin crco = 1'b0;          cq = int'(b4_D);     cload = 1'b1; end
      endcase
    end
  endtask

  task automatic cycle(input logic drst, input logic en, input logic [1:0] md,
                       input logic [3:0] d, input logic clr, input logic [5:0] mask);
    b4_dut_reset = drst; b4_enable = en; b4_mode = md; b4_D = d; mon_clear = clr;
    @(posedge b4_clk); #1;
    model_edge();
    {b4_rco, b4_load, b4_Q} = {crco, cload, 4'(cq)} ^ mask;
    @(negedge b4_clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 b4_reset = 1'b0;
    #1;
    model_clear_all();
    cq = 0; crco = 1'b0; cload = 1'b0;
    {b4_rco, b4_load, b4_Q} = 6'h0;
    check_all();
    @(posedge b4_clk); #1;
    check_all();
    @(negedge b4_clk);
    b4_reset = 1'b1;
  endtask

  initial begin
    logic       r_rst, r_en, r_clr;
    logic [1:0] r_md;
    logic [3:0] r_d;
    logic [5:0] r_mask;

    model_clear_all();
    @(posedge b4_clk);
    @(negedge b4_clk);
    check_all();
    b4_reset = 1'b1;

    // Sync with a DUT reset, then count up through the 15->0 wrap.
    cycle(1, 0, 2'b00, 4'h0, 0, 6'h0);
    repeat (17) cycle(0, 1, 2'b00, 4'h0, 0, 6'h0);
    check_eq("tp1_synced", 32'(syn_o[0]), 32'd1);
    check_eq("tp1_cnt", 32'(cnt0), 32'd0);

    // Load A, count down through 0->F.
    cycle(0, 1, 2'b11, 4'hA, 0, 6'h0);
    repeat (11) cycle(0, 1, 2'b01, 4'h0, 0, 6'h0);
    check_eq("tp2_cnt", 32'(cnt0), 32'd0);

    // Up-by-3 from 13 wraps to 0 with rco; observed Q corrupted to 1.
    cycle(0, 1, 2'b11, 4'd13, 0, 6'h0);
    cycle(0, 1, 2'b10, 4'h0, 0, 6'h01);
    cycle(0, 0, 2'b00, 4'h0, 0, 6'h0);
    check_eq("tp3_err", 32'(err_o[0]), 32'd1);
    check_eq("tp3_cnt", 32'(cnt0), 32'd1);
    check_eq("tp3_first_exp", 32'(fe_o[0]), 32'h20);
    check_eq("tp3_first_obs", 32'(fo_o[0]), 32'h21);
    check_eq("tp3_stop_synced", 32'(syn_o[1]), 32'd0);

    // Back-to-back mismatches: stop-on-error freezes, narrow counter saturates.
    repeat (6) cycle(0, 0, 2'b00, 4'h0, 0, 6'h01);
    check_eq("tp4_stop_cnt", 32'(cnt1), 32'd1);
    check_eq("tp5_sat_cnt", 32'(cnt2), 32'd3);
    cycle(0, 0, 2'b00, 4'h0, 1, 6'h0);
    check_eq("tp5_clear_cnt", 32'(cnt2), 32'd0);
    check_eq("tp5_clear_sticky", 32'(stk_o[2]), 32'd0);
    check_eq("tp4_clear_synced", 32'(syn_o[1]), 32'd0);

    // Asynchronous monitor reset mid-check; stays idle until a resync event.
    cycle(1, 0, 2'b00, 4'h0, 0, 6'h0);
    repeat (3) cycle(0, 1, 2'b00, 4'h0, 0, 6'h0);
    async_reset();
    repeat (4) cycle(0, 1, 2'b00, 4'h0, 0, 6'h04);
    check_eq("tp6_idle_synced", 32'(syn_o[0]), 32'd0);
    check_eq("tp6_idle_cnt", 32'(cnt0), 32'd0);
    cycle(0, 1, 2'b11, 4'h5, 0, 6'h0);
    check_eq("tp6_resync", 32'(syn_o[0]), 32'd1);

    // Randomized traffic with sporadic corruption, clears and resets.
    for (int n = 0; n < 800; n++) begin
      r_rst  = ($urandom_range(0, 24) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_md   = 2'($urandom_range(0, 3));
      r_d    = 4'($urandom_range(0, 15));
      r_clr  = ($urandom_range(0, 39) == 0);
      r_mask = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
      if ($urandom_range(0, 149) == 0) async_reset();
      cycle(r_rst, r_en, r_md, r_d, r_clr, r_mask);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
